// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter sharing one radix-4 Booth multiplier across requesters.
// Define MULT_ARB_ACCUM_EN for per-requester accumulation of products.
module booth_mult_arbiter #(
    parameter int BITWIDTH  = 8,
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = $clog2(NUM_REQ),
    parameter int ACC_GUARD = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*BITWIDTH-1:0]  a_in,
    input  logic [NUM_REQ*BITWIDTH-1:0]  b_in,
`ifdef MULT_ARB_ACCUM_EN
    input  logic [NUM_REQ-1:0]           acc_first,
`endif
    output logic [NUM_REQ-1:0]           gnt,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [ID_W-1:0]              res_id,
`ifdef MULT_ARB_ACCUM_EN
    output logic [2*BITWIDTH+ACC_GUARD-1:0] res
`else
    output logic [2*BITWIDTH-1:0]        res
`endif
);

    logic                       s1_en;
    logic                       s2_en;
    logic                       s1_valid;
    logic                       s2_valid;
    logic                       accept;
    logic [ID_W-1:0]            ptr;
    logic [ID_W-1:0]            idx;
    logic [ID_W-1:0]            gnt_id;
    logic [ID_W-1:0]            s1_id;
    logic [BITWIDTH-1:0]        s1_a;
    logic [BITWIDTH-1:0]        s1_b;
    logic signed [2*BITWIDTH-1:0] a_sx;
    logic signed [2*BITWIDTH-1:0] pp;
    logic signed [2*BITWIDTH-1:0] prod;
    logic [BITWIDTH:0]          b_ext;

    assign res_valid = s2_valid;
    assign s2_en     = !s2_valid || res_ready;
    assign s1_en     = !s1_valid || s2_en;
    assign accept    = |(req & gnt);

    // Scan from ptr upward with wrap; the first requester found wins.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        idx    = '0;
        if (s1_en && !rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = ID_W'((int'(ptr) + i) % NUM_REQ);
                if (gnt == '0 && req[idx]) begin
                    gnt[idx] = 1'b1;
                    gnt_id   = idx;
                end
            end
        end
    end

    // Radix-4 Booth: recode overlapping multiplier triplets into {0,+-1,+-2}.
    always_comb begin
        a_sx  = {{BITWIDTH{s1_a[BITWIDTH-1]}}, s1_a};
        b_ext = {s1_b, 1'b0};
        prod  = '0;
        pp    = '0;
        for (int k = 0; k < BITWIDTH / 2; k++) begin
            case (b_ext[2*k +: 3])
                3'b001, 3'b010: pp = a_sx;
                3'b011:         pp = a_sx <<< 1;
                3'b100:         pp = -(a_sx <<< 1);
                3'b101, 3'b110: pp = -a_sx;
                default:        pp = '0;
            endcase
            prod = prod + (pp <<< (2 * k));
        end
    end

`ifdef MULT_ARB_ACCUM_EN
    localparam int RES_W = 2*BITWIDTH + ACC_GUARD;
    logic             s1_first;
    logic [RES_W-1:0] acc [NUM_REQ];
    logic [RES_W-1:0] new_acc;

    // acc[] is written in the same stage it is read, so same-id
    // back-to-back updates always see the previous sum.
    always_comb begin
        new_acc = (s1_first ? '0 : acc[s1_id])
                + {{ACC_GUARD{prod[2*BITWIDTH-1]}}, prod};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            ptr      <= '0;
            s1_id    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
`ifdef MULT_ARB_ACCUM_EN
            s1_first <= 1'b0;
`endif
        end else if (s1_en) begin
            s1_valid <= accept;
            if (accept) begin
                s1_id <= gnt_id;
                s1_a  <= a_in[gnt_id*BITWIDTH +: BITWIDTH];
                s1_b  <= b_in[gnt_id*BITWIDTH +: BITWIDTH];
`ifdef MULT_ARB_ACCUM_EN
                s1_first <= acc_first[gnt_id];
`endif
                if (gnt_id == ID_W'(NUM_REQ - 1))
                    ptr <= '0;
                else
                    ptr <= gnt_id + ID_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            res      <= '0;
            res_id   <= '0;
`ifdef MULT_ARB_ACCUM_EN
            for (int i = 0; i < NUM_REQ; i++) acc[i] <= '0;
`endif
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                res_id <= s1_id;
`ifdef MULT_ARB_ACCUM_EN
                res        <= new_acc;
                acc[s1_id] <= new_acc;
`else
                res <= prod;
`endif
            end
        end
    end

endmodule

// File: doc/booth_mult_arbiter.md
Name: booth_mult_arbiter

Overview:
- Shares one combinational accurate radix-4 Booth multiplier datapath between NUM_REQ requesters.
- Uses round-robin arbitration into a two-stage pipeline: an operand issue register, the multiplier, then a result register.
- Results return in order, tagged with the requester ID, under a valid/ready backpressure handshake.
- Sits between DNN processing-element lanes and the shared multiplier instance.

Parameters:
- BITWIDTH, 8, operand width. Must be even (radix-4 Booth) and ≥4.
- NUM_REQ, 4, number of requesters. Must be ≥2.
- ID_W, $clog2(NUM_REQ), width of the result tag.
- ACC_GUARD, 8, accumulator guard bits. Used only with MULT_ARB_ACCUM_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester operand-valid.
- a_in  in  NUM_REQ*BITWIDTH  packed multiplicands; requester i occupies slice [i*BITWIDTH +: BITWIDTH].
- b_in  in  NUM_REQ*BITWIDTH  packed multipliers; same packing as a_in.
- gnt  out  NUM_REQ  one-hot grant; a transaction is accepted in a cycle where req[i] && gnt[i].
- res_valid  out  1  result valid.
- res_ready  in  1  consumer ready.
- res_id  out  ID_W  index of the requester that owns the result.
- res  out  2*BITWIDTH  signed product (RES_W = 2*BITWIDTH+ACC_GUARD when MULT_ARB_ACCUM_EN is defined).

Behaviour:
- Arithmetic:
  - Operands and result are two's complement.
  - res = a*b, exact, with no truncation: the full 2*BITWIDTH-bit product.
  - Multiplier path is combinational between the S1 and S2 registers.
- Pipeline occupancy states, given by (s1_valid, s2_valid): EMPTY (0,0), S1ONLY (1,0), S2ONLY (0,1), FULL (1,1).
- Enables:
  - s2_en = !res_valid || res_ready.
  - s1_en = !s1_valid || s2_en.
  - S2 loads when s2_en: s2_valid <= s1_valid; res, res_id <= product and id from S1.
  - S1 loads when s1_en: s1_valid <= |(req & gnt); captures the granted a, b, id.
- Grant:
  - gnt is combinational from req, the round-robin pointer ptr and s1_en.
  - gnt is all-zero when s1_en=0 or req=0.
  - Otherwise gnt is the first set req bit scanning ptr, ptr+1, …, wrapping NUM_REQ-1 → 0.
  - gnt is never asserted for a requester whose req=0.
- Pointer:
  - On an accepted grant to requester i, ptr <= (i+1) mod NUM_REQ.
  - With no grant, ptr holds.
  - Guarantees starvation-freedom: any held req is granted within NUM_REQ accept slots.
- Latency and throughput:
  - A request accepted at edge N gives res_valid=1 after edge N+1 with zero stall (two register stages: S1 at N, S2 at N+1).
  - Sustained throughput is 1 result per cycle with res_ready=1.
- Backpressure:
  - While res_valid && !res_ready, res, res_id and res_valid are held stable.
  - S1 holds if occupied; gnt = 0 when FULL and stalled.
  - No result is dropped or duplicated.
- Simultaneous events: S2 drain (res_ready) and a new grant in the same cycle are both legal; S1 advances into S2 and the new request enters S1.
- Requester contract:
  - a_in/b_in are sampled only on acceptance.
  - A requester may change operands or drop req when not granted; the arbiter must tolerate it.
- Reset:
  - On rst=1 at an edge: s1_valid=0, s2_valid=0 (res_valid=0), res=0, res_id=0, ptr=0; with MULT_ARB_ACCUM_EN, all accumulators = 0.
  - While rst=1, gnt=0.
  - Reset mid-operation discards in-flight transactions with no output for them.
- Order: results leave in acceptance order.

Optional Feature:
- Macro name: MULT_ARB_ACCUM_EN.
- With the macro defined:
  - Adds input acc_first [NUM_REQ], sampled with the operands on acceptance.
  - Adds NUM_REQ accumulators, each RES_W bits.
  - On S2 load: acc[id] <= (first ? 0 : acc[id]) + sign-extended product; res <= the new acc[id] value.
  - Accumulators wrap modulo 2^RES_W.
  - Back-to-back same-id updates must see the previous sum, with no read-after-write hazard.
- Without the macro: no acc_first port, no accumulator storage, res is the plain product of width 2*BITWIDTH.

Test Plan:
All scenarios use BITWIDTH=8, NUM_REQ=4.
- Single request: req=4'b0010, a1=8'sd-7, b1=8'sd13, res_ready=1 → gnt=0010 in one cycle; one cycle later res_valid=1, res=-91 (16'hFFA5), res_id=1.
- Round-robin fairness: req=4'b1111 held, res_ready=1 from reset → gnt sequence 0001, 0010, 0100, 1000, 0001; results in the same ID order, 1 per cycle.
- Backpressure: fill the pipe, then res_ready=0 for 5 cycles → res/res_id stable, gnt=0 after S1 fills; on release, 2 buffered results drain in order with none lost.
- Extremes: a=-128, b=-128 → res=16384 (16'h4000); a=127, b=-128 → res=-16256 (16'hC080); a=0, b=x → 0.
- Reset mid-flight: accept 2 requests, assert rst on the next edge → res_valid=0, ptr=0; first post-reset req=1111 is granted to requester 0.
- Accumulation (MULT_ARB_ACCUM_EN): requester 2 issues (3,4,first=1), (5,6,first=0), (-2,10,first=0) back-to-back → res = 12, 42, 22.
